// File: rtl/ts_pkt_rr_arb_if.sv
// Bus bundle between the packet round-robin arbiter and its channel FIFOs
// and downstream consumer.
//   ch_pkt_rdy   : per-channel "whole packet available"
//   ch_rd_en     : one-hot FIFO read strobe (data returns one cycle later)
//   ts_din_1..4  : FIFO read data, channels 1..4
//   tx_over_full : downstream full, pauses reads
//   ts_dout/_en  : merged TS byte stream
//   cur_ch, busy : current grant and transfer-in-progress status
//   sync_err     : first byte of a packet was not the sync byte
// Modport master is the arbiter; slave is the FIFO/consumer side.
interface ts_pkt_rr_arb_if;
  logic [3:0] ch_pkt_rdy;
  logic [3:0] ch_rd_en;
  logic [7:0] ts_din_1;
  logic [7:0] ts_din_2;
  logic [7:0] ts_din_3;
  logic [7:0] ts_din_4;
  logic       tx_over_full;
  logic [7:0] ts_dout;
  logic       ts_dout_en;
  logic [1:0] cur_ch;
  logic       busy;
  logic       sync_err;

  modport master (
    input  ch_pkt_rdy, ts_din_1, ts_din_2, ts_din_3, ts_din_4, tx_over_full,
    output ch_rd_en, ts_dout, ts_dout_en, cur_ch, busy, sync_err
  );

  modport slave (
    output ch_pkt_rdy, ts_din_1, ts_din_2, ts_din_3, ts_din_4, tx_over_full,
    input  ch_rd_en, ts_dout, ts_dout_en, cur_ch, busy, sync_err
  );
endinterface

// File: rtl/ts_pkt_rr_arb.sv
// Packet-granular round-robin scheduler: grants one of four TS channel
// FIFOs, drains exactly PKT_LEN bytes from it (pausing on tx_over_full),
// spends one GAP cycle, then rotates to the next ready channel.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : ts_pkt_rr_arb_if.master (FIFO handshake, data in/out, status)
module ts_pkt_rr_arb #(
  parameter int unsigned PKT_LEN   = 188,
  parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
  input  logic            clk,
  input  logic            rst,
  ts_pkt_rr_arb_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

  state_t     state, state_n;
  logic [7:0] byte_cnt;
  logic [1:0] last_grant;
  logic [1:0] cur_ch_r;
  logic       busy_r;

  logic       grant_ok;
  logic [1:0] grant_ch;
  logic [1:0] cand;
  logic       rd_fire;
  logic [3:0] rd_en;

  // Output pipeline: stage 1 aligns with FIFO data, stage 2 is the output.
  logic       rd_d1;
  logic       first_d1;
  logic [1:0] ch_d1;
  logic [7:0] din_sel;
  logic [7:0] ts_dout_r;
  logic       ts_dout_en_r;
  logic       sync_err_r;

  // Search last_grant+1, +2, +3, +4 (mod 4); the 2-bit add wraps naturally.
  always_comb begin
    grant_ok = 1'b0;
    grant_ch = last_grant;
    cand     = last_grant;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!grant_ok && bus.ch_pkt_rdy[cand]) begin
        grant_ok = 1'b1;
        grant_ch = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    rd_fire = 1'b0;
    rd_en   = '0;
    case (state)
      IDLE: begin
        if (grant_ok && !bus.tx_over_full) state_n = READ;
      end
      READ: begin
        // Gated by rst so a reset cycle never pops a byte that gets dropped.
        rd_fire         = !bus.tx_over_full && !rst;
        rd_en[cur_ch_r] = rd_fire;
        if (rd_fire && byte_cnt == LAST_IDX) state_n = GAP;
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      last_grant <= 2'd3;
      cur_ch_r   <= '0;
      busy_r     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (state_n == READ) begin
            cur_ch_r   <= grant_ch;
            last_grant <= grant_ch;
            byte_cnt   <= '0;
            busy_r     <= 1'b1;
          end
        end
        READ: begin
          if (rd_fire) byte_cnt <= byte_cnt + 8'd1;
        end
        GAP:     busy_r <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ch_d1)
      2'd0:    din_sel = bus.ts_din_1;
      2'd1:    din_sel = bus.ts_din_2;
      2'd2:    din_sel = bus.ts_din_3;
      default: din_sel = bus.ts_din_4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d1        <= 1'b0;
      first_d1     <= 1'b0;
      ch_d1        <= '0;
      ts_dout_r    <= '0;
      ts_dout_en_r <= 1'b0;
      sync_err_r   <= 1'b0;
    end else begin
      rd_d1        <= rd_fire;
      first_d1     <= rd_fire && (byte_cnt == '0);
      ch_d1        <= cur_ch_r;
      ts_dout_en_r <= rd_d1;
      sync_err_r   <= rd_d1 && first_d1 && (din_sel != SYNC_BYTE);
      if (rd_d1) ts_dout_r <= din_sel;
    end
  end

  assign bus.ch_rd_en   = rd_en;
  assign bus.ts_dout    = ts_dout_r;
  assign bus.ts_dout_en = ts_dout_en_r;
  assign bus.cur_ch     = cur_ch_r;
  assign bus.busy       = busy_r;
  assign bus.sync_err   = sync_err_r;

endmodule

// File: tb/tb_ts_pkt_rr_arb.sv
module tb_ts_pkt_rr_arb;
  localparam int unsigned PKT_LEN = 188;
  localparam logic [7:0]  SYNC    = 8'h47;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ts_pkt_rr_arb_if bus ();

  ts_pkt_rr_arb #(.PKT_LEN(PKT_LEN), .SYNC_BYTE(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: what kind of cycle the scheduler is in, derived from
  // the grant/packet/gap rules, plus a queue of bytes owed to the output.
  typedef enum {K_IDLE, K_READ, K_GAP, K_RST} kind_t;

  kind_t       prev_kind;
  logic [3:0]  prev_rdy;
  logic        prev_full;
  int unsigned m_last, m_cur, m_cnt;
  logic [7:0]  exp_q[$];
  bit          first_q[$];
  bit          hist0, hist1;
  logic [7:0]  m_last_out;
  int          next_ch;
  logic [7:0]  next_din;
  bit          pat_mode, force_bad, burst_bad;
  int unsigned bursts_done;
  int unsigned en_count, serr_count;
  int unsigned grant_log[$];
  int unsigned gap_log[$];
  int unsigned cyc, last_rd_cyc;
  bit          have_last_rd;

  function automatic int unsigned rr_pick(input int unsigned last, input logic [3:0] mask);
    for (int unsigned i = 1; i <= 4; i++)
      if (mask[(last + i) % 4]) return (last + i) % 4;
    return last;
  endfunction

  task automatic model_reset();
    prev_kind    = K_RST;
    m_last       = 3;
    m_cur        = 0;
    m_cnt        = 0;
    exp_q.delete();
    first_q.delete();
    hist0        = 0;
    hist1        = 0;
    m_last_out   = 8'h00;
    next_ch      = -1;
    have_last_rd = 0;
  endtask

  task automatic drive_din();
    logic [7:0] r [4];
    for (int i = 0; i < 4; i++) r[i] = (i == next_ch) ? next_din : 8'($urandom);
    bus.ts_din_1 = r[0];
    bus.ts_din_2 = r[1];
    bus.ts_din_3 = r[2];
    bus.ts_din_4 = r[3];
  endtask

  // One clock cycle, entered and left at the falling edge. The caller has
  // already set ch_pkt_rdy / tx_over_full for this cycle.
  task automatic cycle();
    kind_t      kind;
    bit         fire;
    logic [3:0] exp_rd;
    logic [7:0] b;
    bit         f;
    drive_din();
    #1;
    check("dout_en", bus.ts_dout_en, hist1);
    if (bus.ts_dout_en) en_count++;
    if (bus.sync_err) serr_count++;
    if (hist1) begin
      check("exp_q_avail", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        f = first_q.pop_front();
        check("dout", bus.ts_dout, b);
        check("sync_err", bus.sync_err, 32'(f && (b != SYNC)));
        m_last_out = b;
      end
    end else begin
      check("dout_hold", bus.ts_dout, m_last_out);
      check("sync_err_idle", bus.sync_err, 0);
    end

    case (prev_kind)
      K_IDLE:  kind = (prev_rdy != 4'b0 && !prev_full) ? K_READ : K_IDLE;
      K_READ:  kind = (m_cnt == PKT_LEN) ? K_GAP : K_READ;
      default: kind = K_IDLE;
    endcase
    if (prev_kind == K_IDLE && kind == K_READ) begin
      m_cur     = rr_pick(m_last, prev_rdy);
      m_last    = m_cur;
      m_cnt     = 0;
      burst_bad = force_bad || (!pat_mode && $urandom_range(3) == 0);
      force_bad = 0;
      grant_log.push_back(32'(bus.cur_ch));
    end
    check("busy", bus.busy, 32'(kind != K_IDLE));
    check("cur_ch", bus.cur_ch, m_cur);

    fire   = (kind == K_READ) && !bus.tx_over_full;
    exp_rd = fire ? 4'(1 << m_cur) : 4'b0;
    check("rd_en", bus.ch_rd_en, exp_rd);

    if (bus.ch_rd_en != 4'b0) begin
      if (have_last_rd && kind == K_READ && m_cnt == 0)
        gap_log.push_back(cyc - last_rd_cyc - 1);
      last_rd_cyc  = cyc;
      have_last_rd = 1;
    end

    next_ch = -1;
    if (fire) begin
      f = (m_cnt == 0);
      if (f) b = burst_bad ? (pat_mode ? 8'h00 : 8'($urandom)) : SYNC;
      else   b = pat_mode ? 8'(m_cnt) : 8'($urandom);
      exp_q.push_back(b);
      first_q.push_back(f);
      next_ch  = int'(m_cur);
      next_din = b;
      m_cnt++;
      if (m_cnt == PKT_LEN) bursts_done++;
    end
    hist1     = hist0;
    hist0     = fire;
    prev_kind = kind;
    prev_rdy  = bus.ch_pkt_rdy;
    prev_full = bus.tx_over_full;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tx_over_full = 1'b0;
    next_ch = -1;
    drive_din();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rd_en", bus.ch_rd_en, 0);
    check("rst_dout_en", bus.ts_dout_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cur_ch", bus.cur_ch, 0);
    check("rst_dout", bus.ts_dout, 0);
    check("rst_sync_err", bus.sync_err, 0);
    model_reset();
  endtask

  task automatic run_bursts(input int unsigned n, input int unsigned budget);
    int unsigned target = bursts_done + n;
    int unsigned k = 0;
    while (bursts_done < target && k < budget) begin
      cycle();
      k++;
    end
    check("burst_timeout", 32'(bursts_done >= target), 1);
  endtask

  task automatic drain(input int unsigned n);
    bus.ch_pkt_rdy = 4'b0;
    repeat (n) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int unsigned exp_order [5] = '{0, 1, 2, 3, 0};
    bus.ch_pkt_rdy   = 4'b0;
    bus.tx_over_full = 1'b0;
    bus.ts_din_1 = 8'h00; bus.ts_din_2 = 8'h00;
    bus.ts_din_3 = 8'h00; bus.ts_din_4 = 8'h00;
    pat_mode = 1; force_bad = 0; burst_bad = 0;
    bursts_done = 0; cyc = 0; last_rd_cyc = 0;
    model_reset();

    // Single channel packet: 0x47, 0x01..0xBB.
    do_reset();
    en_count = 0; serr_count = 0;
    bus.ch_pkt_rdy = 4'b0001;
    run_bursts(1, 400);
    drain(5);
    check("single_bytes", en_count, PKT_LEN);
    check("single_sync_err", serr_count, 0);

    // All channels ready: strict rotation with two idle cycles between bursts.
    do_reset();
    grant_log.delete(); gap_log.delete();
    bus.ch_pkt_rdy = 4'b1111;
    run_bursts(5, 5 * 200);
    drain(5);
    check("rot_grants", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) check("rot_order", grant_log[i], exp_order[i]);
    check("rot_gaps", gap_log.size(), 4);
    foreach (gap_log[i]) check("rot_gap_len", gap_log[i], 2);

    // Reset in the middle of a packet, then grant from the restored pointer.
    do_reset();
    bus.ch_pkt_rdy = 4'b0001;
    k = 0;
    while (!(prev_kind == K_READ && m_cnt == 100) && k < 300) begin
      cycle();
      k++;
    end
    check("mid_reach_timeout", 32'(k < 300), 1);
    do_reset();
    grant_log.delete();
    bus.ch_pkt_rdy = 4'b0010;
    run_bursts(1, 400);
    bus.ch_pkt_rdy = 4'b1001;
    run_bursts(2, 800);
    drain(5);
    check("post_rst_grants", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("post_rst_first", grant_log[0], 1);
      check("wrap_grant_a", grant_log[1], 3);
      check("wrap_grant_b", grant_log[2], 0);
    end

    // Backpressure for 10 cycles at byte 50.
    en_count = 0;
    bus.ch_pkt_rdy = 4'b0100;
    k = 0;
    while (!(prev_kind == K_READ && m_cnt == 50) && k < 300) begin
      cycle();
      k++;
    end
    check("stall_reach_timeout", 32'(k < 300), 1);
    bus.tx_over_full = 1'b1;
    repeat (10) cycle();
    bus.tx_over_full = 1'b0;
    run_bursts(1, 400);
    drain(5);
    check("stall_bytes", en_count, PKT_LEN);

    // Corrupted sync byte on channel 2's packet.
    en_count = 0; serr_count = 0;
    force_bad = 1;
    bus.ch_pkt_rdy = 4'b0010;
    run_bursts(1, 400);
    drain(5);
    check("badsync_pulses", serr_count, 1);
    check("badsync_bytes", en_count, PKT_LEN);

    // Randomized readiness, backpressure and sync corruption.
    pat_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      bus.ch_pkt_rdy   = 4'($urandom);
      bus.tx_over_full = ($urandom_range(9) == 0);
      cycle();
    end
    bus.tx_over_full = 1'b0;
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ts_pkt_rr_arb.md
Name: ts_pkt_rr_arb

Overview:
- Packet-granular round-robin scheduler that shares one downstream TS byte output between four upstream TS channel packet FIFOs.
- Each channel FIFO holds whole 188-byte packets processed by the per-channel TS analysis stage.
- The block picks a channel, drains exactly one packet from it, then rotates.
- Downstream backpressure (tx_over_full) pauses reading byte-by-byte; a packet is never interleaved with another.

Parameters:
- PKT_LEN, 188, bytes per TS packet (valid range 2..255).
- SYNC_BYTE, 8'h47, expected first byte of every packet.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ch_pkt_rdy  in  4  bit i=1: channel i+1 FIFO holds at least one complete packet
- ch_rd_en  out  4  one-hot FIFO read strobe; the FIFO returns data 1 cycle after the strobe
- ts_din_1..ts_din_4  in  8 each  FIFO read data, channels 1..4
- tx_over_full  in  1  downstream full; no new read is issued while it is high
- ts_dout  out  8  merged TS byte
- ts_dout_en  out  1  ts_dout valid
- cur_ch  out  2  channel currently granted (0..3)
- busy  out  1  packet transfer in progress
- sync_err  out  1  one-cycle pulse when a packet's first output byte is not SYNC_BYTE

Behaviour:
- Reset (synchronous, highest priority, may occur mid-packet):
  - All outputs go to 0.
  - State goes to IDLE, byte_cnt to 0, last_grant to 3 (so channel 0 is served first).
  - The 2-stage output pipeline is cleared; in-flight bytes are dropped.
- States: IDLE, READ, GAP.
- IDLE:
  - If (ch_pkt_rdy != 0) and !tx_over_full, grant the first ready channel searching from last_grant+1 (mod 4) upward.
  - On grant: cur_ch = grant, last_grant = grant, byte_cnt = 0, busy = 1, next state READ.
  - Otherwise stay in IDLE.
- READ:
  - ch_rd_en[cur_ch] = !tx_over_full; all other bits are 0.
  - Each cycle with a read asserted, byte_cnt increments.
  - When the read fires with byte_cnt == PKT_LEN-1, next state is GAP.
  - tx_over_full high holds byte_cnt and issues no read. No timeout.
  - ch_pkt_rdy is ignored during READ; a deasserted rdy mid-packet does not abort the transfer.
- GAP: exactly 1 cycle with no reads, allowing the upstream ch_pkt_rdy to update. Then busy = 0 and next state IDLE.
- Datapath latency:
  - Read strobe at cycle t; FIFO data at t+1, which the block captures into a register.
  - ts_dout / ts_dout_en are presented at t+2.
  - Channel select for the mux is the pipelined cur_ch aligned to t+1, not the live value.
- ts_dout_en is the rd_en OR delayed 2 cycles. ts_dout holds its last value when en is low.
- Sync check:
  - The first byte of each packet (byte_cnt was 0 at read) carries a pipelined first flag.
  - If that output byte != SYNC_BYTE, sync_err pulses in the same cycle as its ts_dout_en.
  - The data is still forwarded.
- Maximum throughput is PKT_LEN bytes per PKT_LEN+2 cycles (IDLE + GAP overhead).
- cur_ch holds its value after the packet until the next grant.

Test Plan:
- Reset, ch_pkt_rdy=4'b0001, din_1 = 0x47 then 0x01..0xBB, tx_over_full=0:
  - ch_rd_en=4'b0001 for exactly 188 consecutive cycles.
  - ts_dout_en rises 2 cycles after the first read; 188 bytes 0x47,0x01..0xBB out.
  - sync_err stays 0.
- ch_pkt_rdy=4'b1111 held constant: grants occur in order 0,1,2,3,0; each burst is 188 reads; there are 2 idle cycles (GAP + IDLE) between bursts.
- last_grant=1, ch_pkt_rdy=4'b1001: the next grant is channel 3, then channel 0.
- tx_over_full high for 10 cycles at byte_cnt=50:
  - No rd_en during those cycles; byte_cnt holds at 50.
  - ts_dout_en gap of 10 cycles appears 2 cycles later.
  - Total output is still 188 bytes.
- First byte of a ch2 packet = 0x00: sync_err pulses exactly once, coincident with that byte's ts_dout_en; the remaining 187 bytes are forwarded.
- rst asserted at byte_cnt=100:
  - The next cycle has rd_en=0, ts_dout_en=0, busy=0, cur_ch=0.
  - After release with ch_pkt_rdy=4'b0010, channel 1 is granted (channel 0 not ready).
